vx_csr_access_unit: RTL and testbench

Execute-stage CSR access unit, directly upstream of the core's CSR register file (`csr_data` block). It accepts one CSR instruction per cycle from dispatch and reads the addressed CSR. For CSRRW/CSRRS/CSRRC it computes the read-modify-write value and issues the write. It returns the old CSR value, replicated across lanes, through a 2-entry response buffer to commit. It also stalls reads of floating-point flags while FPU ops for the same warp are in flight.

---
 rtl/csr_pkg.sv | 48 ++++
 rtl/vx_csr_access_unit_checker.sv | 17 +
 rtl/vx_csr_rsp_fifo.sv | 62 ++++++
 rtl/vx_csr_access_unit.sv | 152 +++++++++++++++
 tb/tb_vx_csr_access_unit.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the CSR access path: op encodings, FP flag CSR
// addresses, the response record layout and the read-modify-write helper.
package csr_pkg;

  localparam logic [1:0] CSR_OP_ILL = 2'b00;
  localparam logic [1:0] CSR_OP_RW  = 2'b01;
  localparam logic [1:0] CSR_OP_RS  = 2'b10;
  localparam logic [1:0] CSR_OP_RC  = 2'b11;

  localparam logic [11:0] CSR_ADDR_FFLAGS = 12'h001;
  localparam logic [11:0] CSR_ADDR_FCSR   = 12'h003;

  // Field widths of the default core configuration.
  localparam int CSR_UUID_BITS   = 44;
  localparam int CSR_NW_BITS     = 2;
  localparam int CSR_NUM_THREADS = 4;

  // Response record for the default configuration. Units built with other
  // widths declare a record with the same field order and their own widths.
  typedef struct packed {
    logic [CSR_UUID_BITS-1:0]   uuid;
    logic [CSR_NW_BITS-1:0]     wid;
    logic [CSR_NUM_THREADS-1:0] tmask;
    logic [31:0]                pc;
    logic [4:0]                 rd;
    logic                       wb;
    logic [31:0]                data;
  } csr_rsp_t;

  // CSRs whose value depends on in-flight FPU results.
  function automatic logic is_fp_flag_addr(input logic [11:0] addr);
    return (addr == CSR_ADDR_FFLAGS) || (addr == CSR_ADDR_FCSR);
  endfunction

  // New CSR value for an RMW op. An illegal op behaves as set.
  function automatic logic [31:0] csr_rmw(input logic [1:0]  op,
                                          input logic [31:0] old_val,
                                          input logic [31:0] operand);
    logic [31:0] result;
    case (op)
      CSR_OP_RW: result = operand;
      CSR_OP_RC: result = old_val & ~operand;
      default:   result = old_val | operand;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/vx_csr_access_unit_checker.sv
// Protocol checks on the request side of the CSR access unit.
module vx_csr_access_unit_checker
  import csr_pkg::*;
(
  input logic       clk,
  input logic       reset,
  input logic       req_valid,
  input logic [1:0] req_op
);

  // A valid request must carry one of the three defined CSR ops.
  property p_legal_op;
    @(posedge clk) disable iff (reset) req_valid |-> (req_op != CSR_OP_ILL);
  endproperty
  a_legal_op: assert property (p_legal_op);

endmodule

// File: rtl/vx_csr_rsp_fifo.sv
// Two-entry in-order response buffer with an occupancy count.
// Readiness on the push side depends only on the registered count.
module vx_csr_rsp_fifo
  import csr_pkg::*;
#(
  parameter type entry_t = csr_rsp_t
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_valid,
  output logic       push_ready,
  input  entry_t     push_data,
  output logic       pop_valid,
  input  logic       pop_ready,
  output entry_t     pop_data,
  output logic [1:0] count
);

  entry_t     mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       push_fire_s;
  logic       pop_fire_s;

  assign push_ready  = (count_q != 2'd2);
  assign pop_valid   = (count_q != 2'd0);
  assign push_fire_s = push_valid & push_ready;
  assign pop_fire_s  = pop_valid & pop_ready;
  assign pop_data    = mem_q[rd_ptr_q];
  assign count       = count_q;

  // Next occupancy: simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_fire_s, pop_fire_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count state; reset discards any buffered entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push_fire_s) wr_ptr_q <= ~wr_ptr_q;
      if (pop_fire_s)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Entry storage; contents are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (push_fire_s) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/vx_csr_access_unit.sv
// Execute-stage CSR access unit: reads the addressed CSR, issues the
// read-modify-write for CSRRW/RS/RC and returns the old value, replicated
// across lanes, through a 2-entry response buffer. FFLAGS/FCSR reads wait
// while the warp still has FPU ops in flight.
module vx_csr_access_unit
  import csr_pkg::*;
#(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int UUID_BITS   = 44,
  parameter int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,

  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [UUID_BITS-1:0]        req_uuid,
  input  logic [NW_BITS-1:0]          req_wid,
  input  logic [NUM_THREADS-1:0]      req_tmask,
  input  logic [31:0]                 req_pc,
  input  logic [4:0]                  req_rd,
  input  logic                        req_wb,
  input  logic [11:0]                 req_addr,
  input  logic [1:0]                  req_op,
  input  logic                        req_use_imm,
  input  logic [4:0]                  req_imm,
  input  logic [4:0]                  req_rs1,
  input  logic [31:0]                 req_rs1_data,

  input  logic [NUM_WARPS-1:0]        fpu_pending,

  output logic                        csr_read_enable,
  output logic [UUID_BITS-1:0]        csr_read_uuid,
  output logic [11:0]                 csr_read_addr,
  output logic [NW_BITS-1:0]          csr_read_wid,
  input  logic [31:0]                 csr_read_data,

  output logic                        csr_write_enable,
  output logic [UUID_BITS-1:0]        csr_write_uuid,
  output logic [11:0]                 csr_write_addr,
  output logic [NW_BITS-1:0]          csr_write_wid,
  output logic [31:0]                 csr_write_data,

  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [UUID_BITS-1:0]        rsp_uuid,
  output logic [NW_BITS-1:0]          rsp_wid,
  output logic [NUM_THREADS-1:0]      rsp_tmask,
  output logic [31:0]                 rsp_pc,
  output logic [4:0]                  rsp_rd,
  output logic                        rsp_wb,
  output logic [NUM_THREADS-1:0][31:0] rsp_data,

  output logic                        busy
);

  // Response record sized for this instance.
  typedef struct packed {
    logic [UUID_BITS-1:0]   uuid;
    logic [NW_BITS-1:0]     wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [31:0]            pc;
    logic [4:0]             rd;
    logic                   wb;
    logic [31:0]            data;
  } rsp_entry_t;

  logic        fp_hazard_s;
  logic        fifo_push_ready_s;
  logic        fire_s;
  logic [31:0] operand_s;
  logic        src_zero_s;
  logic        wr_allowed_s;
  logic [31:0] wr_data_s;
  logic [1:0]  count_s;
  rsp_entry_t  push_entry_s;
  rsp_entry_t  pop_entry_s;

  // Flag reads must wait for the warp's outstanding FPU ops to retire.
  assign fp_hazard_s = is_fp_flag_addr(req_addr) & fpu_pending[req_wid];

  // Ready depends only on reset, the hazard and the registered count.
  assign req_ready = ~reset & ~fp_hazard_s & fifo_push_ready_s;
  assign fire_s    = req_valid & req_ready;

  // Operand selection, RMW value and whether this op may write at all.
  always_comb begin
    operand_s  = req_use_imm ? {27'd0, req_imm} : req_rs1_data;
    src_zero_s = req_use_imm ? (req_imm == 5'd0) : (req_rs1 == 5'd0);
    wr_data_s  = csr_rmw(req_op, csr_read_data, operand_s);
    case (req_op)
      CSR_OP_RW:            wr_allowed_s = 1'b1;
      CSR_OP_RS, CSR_OP_RC: wr_allowed_s = ~src_zero_s;
      default:              wr_allowed_s = 1'b0;
    endcase
  end

  // Read port follows the request directly; a hazard keeps it idle.
  assign csr_read_enable = req_valid & ~fp_hazard_s;
  assign csr_read_uuid   = req_uuid;
  assign csr_read_addr   = req_addr;
  assign csr_read_wid    = req_wid;

  // The write commits at the accepting edge, so a following request
  // reads the updated value without any bypass.
  assign csr_write_enable = fire_s & wr_allowed_s;
  assign csr_write_uuid   = req_uuid;
  assign csr_write_addr   = req_addr;
  assign csr_write_wid    = req_wid;
  assign csr_write_data   = wr_data_s;

  assign push_entry_s.uuid  = req_uuid;
  assign push_entry_s.wid   = req_wid;
  assign push_entry_s.tmask = req_tmask;
  assign push_entry_s.pc    = req_pc;
  assign push_entry_s.rd    = req_rd;
  assign push_entry_s.wb    = req_wb;
  assign push_entry_s.data  = csr_read_data;

  vx_csr_rsp_fifo #(
    .entry_t (rsp_entry_t)
  ) u_rsp_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_valid (fire_s),
    .push_ready (fifo_push_ready_s),
    .push_data  (push_entry_s),
    .pop_valid  (rsp_valid),
    .pop_ready  (rsp_ready),
    .pop_data   (pop_entry_s),
    .count      (count_s)
  );

  assign rsp_uuid  = pop_entry_s.uuid;
  assign rsp_wid   = pop_entry_s.wid;
  assign rsp_tmask = pop_entry_s.tmask;
  assign rsp_pc    = pop_entry_s.pc;
  assign rsp_rd    = pop_entry_s.rd;
  assign rsp_wb    = pop_entry_s.wb;
  assign rsp_data  = {NUM_THREADS{pop_entry_s.data}};

  assign busy = req_valid | (count_s != 2'd0);

  vx_csr_access_unit_checker u_checker (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op)
  );

endmodule

// File: tb/tb_vx_csr_access_unit.sv
// Randomized bench for vx_csr_access_unit with a queue-based reference
// model, a behavioural CSR register file and directed literal checks.
module tb_vx_csr_access_unit;

  localparam int NW  = 4;
  localparam int NT  = 4;
  localparam int UB  = 44;
  localparam int NWB = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 req_valid, req_ready;
  logic [UB-1:0]        req_uuid;
  logic [NWB-1:0]       req_wid;
  logic [NT-1:0]        req_tmask;
  logic [31:0]          req_pc;
  logic [4:0]           req_rd;
  logic                 req_wb;
  logic [11:0]          req_addr;
  logic [1:0]           req_op;
  logic                 req_use_imm;
  logic [4:0]           req_imm, req_rs1;
  logic [31:0]          req_rs1_data;
  logic [NW-1:0]        fpu_pending;
  logic                 csr_read_enable;
  logic [UB-1:0]        csr_read_uuid;
  logic [11:0]          csr_read_addr;
  logic [NWB-1:0]       csr_read_wid;
  logic [31:0]          csr_read_data;
  logic                 csr_write_enable;
  logic [UB-1:0]        csr_write_uuid;
  logic [11:0]          csr_write_addr;
  logic [NWB-1:0]       csr_write_wid;
  logic [31:0]          csr_write_data;
  logic                 rsp_valid, rsp_ready;
  logic [UB-1:0]        rsp_uuid;
  logic [NWB-1:0]       rsp_wid;
  logic [NT-1:0]        rsp_tmask;
  logic [31:0]          rsp_pc;
  logic [4:0]           rsp_rd;
  logic                 rsp_wb;
  logic [NT-1:0][31:0]  rsp_data;
  logic                 busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vx_csr_access_unit #(.NUM_WARPS(NW), .NUM_THREADS(NT), .UUID_BITS(UB)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_uuid(req_uuid),
    .req_wid(req_wid), .req_tmask(req_tmask), .req_pc(req_pc), .req_rd(req_rd),
    .req_wb(req_wb), .req_addr(req_addr), .req_op(req_op),
    .req_use_imm(req_use_imm), .req_imm(req_imm), .req_rs1(req_rs1),
    .req_rs1_data(req_rs1_data), .fpu_pending(fpu_pending),
    .csr_read_enable(csr_read_enable), .csr_read_uuid(csr_read_uuid),
    .csr_read_addr(csr_read_addr), .csr_read_wid(csr_read_wid),
    .csr_read_data(csr_read_data),
    .csr_write_enable(csr_write_enable), .csr_write_uuid(csr_write_uuid),
    .csr_write_addr(csr_write_addr), .csr_write_wid(csr_write_wid),
    .csr_write_data(csr_write_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_uuid(rsp_uuid),
    .rsp_wid(rsp_wid), .rsp_tmask(rsp_tmask), .rsp_pc(rsp_pc), .rsp_rd(rsp_rd),
    .rsp_wb(rsp_wb), .rsp_data(rsp_data), .busy(busy)
  );

  // Power-on CSR contents, shared by the register file and the model.
  function automatic logic [31:0] csr_init(input int w, input int a);
    if (a == 'h340) return 32'h0;
    if (a == 'h300) return 32'h8;
    if (a == 'hB00) return 32'h1234_5678 + 32'(w);
    return 32'hA5A5_0000 ^ 32'(a) ^ (32'(w) << 12);
  endfunction

  // Behavioural CSR register file (the csr_data block the unit talks to).
  logic        rf_init;
  logic [31:0] rf_val [NW*4096];
  always @(posedge clk) begin
    if (rf_init) begin
      for (int k = 0; k < NW*4096; k++) rf_val[k] <= csr_init(k / 4096, k % 4096);
    end else if (csr_write_enable) begin
      rf_val[{csr_write_wid, csr_write_addr}] <= csr_write_data;
    end
  end
  assign csr_read_data = rf_val[{csr_read_wid, csr_read_addr}];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [UB-1:0]  uuid;
    logic [NWB-1:0] wid;
    logic [NT-1:0]  tmask;
    logic [31:0]    pc;
    logic [4:0]     rd;
    logic           wb;
    logic [31:0]    data;
  } exp_rsp_t;

  exp_rsp_t    mq[$];
  logic [31:0] mdl_csr [int];

  function automatic logic [31:0] mdl_read(input int key);
    if (mdl_csr.exists(key)) return mdl_csr[key];
    return csr_init(key / 4096, key % 4096);
  endfunction

  task automatic model_check();
    logic hz, rdy, fr, sz, we;
    logic [31:0] opnd, oldv, newv;
    exp_rsp_t e;
    int key;
    key  = int'(req_wid) * 4096 + int'(req_addr);
    hz   = (req_addr == 12'h001 || req_addr == 12'h003) && fpu_pending[req_wid];
    rdy  = !reset && !hz && (mq.size() < 2);
    fr   = req_valid && rdy;
    opnd = req_use_imm ? 32'(req_imm) : req_rs1_data;
    sz   = req_use_imm ? (req_imm == 5'd0) : (req_rs1 == 5'd0);
    oldv = mdl_read(key);
    if (req_op == 2'b01) begin
      newv = opnd;           we = fr;
    end else if (req_op == 2'b10) begin
      newv = oldv | opnd;    we = fr && !sz;
    end else begin
      newv = oldv & ~opnd;   we = fr && !sz;
    end

    chk("req_ready", req_ready, rdy);
    chk("read_en", csr_read_enable, req_valid && !hz);
    if (req_valid && !hz) begin
      chk("read_addr", csr_read_addr, req_addr);
      chk("read_wid", csr_read_wid, req_wid);
      chk("read_uuid", csr_read_uuid, req_uuid);
    end
    chk("write_en", csr_write_enable, we);
    if (we) begin
      chk("write_data", csr_write_data, newv);
      chk("write_addr", csr_write_addr, req_addr);
      chk("write_wid", csr_write_wid, req_wid);
      chk("write_uuid", csr_write_uuid, req_uuid);
    end
    chk("busy", busy, req_valid || (mq.size() > 0));
    chk("rsp_valid", rsp_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      e = mq[0];
      chk("rsp_uuid", rsp_uuid, e.uuid);
      chk("rsp_wid", rsp_wid, e.wid);
      chk("rsp_tmask", rsp_tmask, e.tmask);
      chk("rsp_pc", rsp_pc, e.pc);
      chk("rsp_rd", rsp_rd, e.rd);
      chk("rsp_wb", rsp_wb, e.wb);
      for (int l = 0; l < NT; l++) chk("rsp_data", rsp_data[l], e.data);
    end

    if (reset) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && rsp_ready) void'(mq.pop_front());
      if (fr) begin
        e.uuid = req_uuid; e.wid = req_wid; e.tmask = req_tmask; e.pc = req_pc;
        e.rd = req_rd; e.wb = req_wb; e.data = oldv;
        mq.push_back(e);
      end
      if (we) mdl_csr[key] = newv;
    end
  endtask

  // Single compare process: inputs change at negedge, outputs checked 2 later.
  always @(negedge clk) begin
    #2;
    model_check();
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [1:0] op, input logic [11:0] addr,
                       input logic [NWB-1:0] wid, input logic ui, input logic [4:0] imm,
                       input logic [4:0] rs1, input logic [31:0] d, input logic [UB-1:0] uid);
    req_valid = v; req_op = op; req_addr = addr; req_wid = wid;
    req_use_imm = ui; req_imm = imm; req_rs1 = rs1; req_rs1_data = d;
    req_uuid = uid; req_tmask = uid[3:0] ^ 4'hA; req_pc = 32'h8000_0000 + uid[31:0];
    req_rd = uid[4:0]; req_wb = uid[0];
  endtask

  logic [11:0] addr_tab [6];

  initial begin
    addr_tab[0] = 12'h001; addr_tab[1] = 12'h003; addr_tab[2] = 12'h300;
    addr_tab[3] = 12'h340; addr_tab[4] = 12'hB00; addr_tab[5] = 12'h7C0;
    reset = 1'b1; rf_init = 1'b1; rsp_ready = 1'b1; fpu_pending = '0;
    drive(1'b0, 2'b01, 12'h000, 2'd0, 1'b0, 5'd0, 5'd0, 32'h0, 44'd0);

    @(negedge clk); rf_init = 1'b0;
    #1; chk("rst_rsp_valid", rsp_valid, 1'b0); chk("rst_busy", busy, 1'b0);
    chk("rst_ready", req_ready, 1'b0);
    @(negedge clk); reset = 1'b0;

    // CSRRW 0x340: old 0, write DEADBEEF, response 0 on all lanes.
    @(negedge clk); drive(1'b1, 2'b01, 12'h340, 2'd0, 1'b0, 5'd0, 5'd5, 32'hDEADBEEF, 44'd1);
    #1; chk("t1_we", csr_write_enable, 1'b1); chk("t1_wdata", csr_write_data, 32'hDEADBEEF);
    @(negedge clk); req_valid = 1'b0;
    #1; chk("t1_rsp_valid", rsp_valid, 1'b1);
    for (int l = 0; l < NT; l++) chk("t1_rsp_lane", rsp_data[l], 32'h0);

    // CSRRS 0x300 |= 3 then CSRRC 0x300 &= ~1 back to back.
    @(negedge clk); drive(1'b1, 2'b10, 12'h300, 2'd0, 1'b1, 5'd3, 5'd0, 32'h0, 44'd2);
    #1; chk("t2_we_rs", csr_write_enable, 1'b1); chk("t2_wdata_rs", csr_write_data, 32'hB);
    @(negedge clk); drive(1'b1, 2'b11, 12'h300, 2'd0, 1'b1, 5'd1, 5'd0, 32'h0, 44'd3);
    #1; chk("t2_we_rc", csr_write_enable, 1'b1); chk("t2_wdata_rc", csr_write_data, 32'hA);
    chk("t2_rsp0", rsp_data[0], 32'h8);
    @(negedge clk); req_valid = 1'b0;
    #1; chk("t2_rsp1", rsp_data[3], 32'hB);

    // CSRRS MCYCLE with x0: read only.
    @(negedge clk); drive(1'b1, 2'b10, 12'hB00, 2'd0, 1'b0, 5'd0, 5'd0, 32'hFFFFFFFF, 44'd4);
    #1; chk("t3_we", csr_write_enable, 1'b0); chk("t3_re", csr_read_enable, 1'b1);
    @(negedge clk); req_valid = 1'b0;
    #1; chk("t3_rsp", rsp_data[1], 32'h1234_5678);

    // FFLAGS read for wid 2 held by its pending FPU op for 5 cycles.
    @(negedge clk); fpu_pending = 4'b0100;
    drive(1'b1, 2'b10, 12'h001, 2'd2, 1'b0, 5'd0, 5'd0, 32'h0, 44'd5);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1; chk("t4_ready_hz", req_ready, 1'b0); chk("t4_re_hz", csr_read_enable, 1'b0);
    end
    @(negedge clk); fpu_pending = 4'b0000;
    #1; chk("t4_ready_rel", req_ready, 1'b1); chk("t4_re_rel", csr_read_enable, 1'b1);
    @(negedge clk); fpu_pending = 4'b0100;
    drive(1'b1, 2'b10, 12'h001, 2'd0, 1'b0, 5'd0, 5'd0, 32'h0, 44'd6);
    #1; chk("t4_ready_w0", req_ready, 1'b1);
    @(negedge clk); req_valid = 1'b0; fpu_pending = 4'b0000;

    // Backpressure: two accepted, third held until count drops.
    @(negedge clk); rsp_ready = 1'b0;
    drive(1'b1, 2'b10, 12'h340, 2'd1, 1'b0, 5'd0, 5'd0, 32'h0, 44'd7);
    #1; chk("t5_ready_a", req_ready, 1'b1);
    @(negedge clk); drive(1'b1, 2'b10, 12'h340, 2'd1, 1'b0, 5'd0, 5'd0, 32'h0, 44'd8);
    #1; chk("t5_ready_b", req_ready, 1'b1);
    @(negedge clk); drive(1'b1, 2'b10, 12'h340, 2'd1, 1'b0, 5'd0, 5'd0, 32'h0, 44'd9);
    #1; chk("t5_ready_full", req_ready, 1'b0); chk("t5_uuid7", rsp_uuid, 44'd7);
    @(negedge clk); rsp_ready = 1'b1;
    #1; chk("t5_ready_full_pop", req_ready, 1'b0); chk("t5_uuid7b", rsp_uuid, 44'd7);
    @(negedge clk);
    #1; chk("t5_ready_c", req_ready, 1'b1); chk("t5_uuid8", rsp_uuid, 44'd8);
    @(negedge clk); req_valid = 1'b0;
    #1; chk("t5_uuid9", rsp_uuid, 44'd9);
    @(negedge clk);
    #1; chk("t5_empty", rsp_valid, 1'b0);

    // Reset with a full buffer discards it and blocks writes.
    @(negedge clk); rsp_ready = 1'b0;
    drive(1'b1, 2'b01, 12'h340, 2'd3, 1'b0, 5'd0, 5'd1, 32'h1111, 44'd10);
    @(negedge clk); drive(1'b1, 2'b01, 12'h340, 2'd3, 1'b0, 5'd0, 5'd1, 32'h2222, 44'd11);
    @(negedge clk); reset = 1'b1;
    drive(1'b1, 2'b01, 12'h340, 2'd3, 1'b0, 5'd0, 5'd1, 32'h3333, 44'd12);
    #1; chk("t6_full", rsp_valid, 1'b1); chk("t6_we_rst", csr_write_enable, 1'b0);
    chk("t6_ready_rst", req_ready, 1'b0);
    @(negedge clk); reset = 1'b0; req_valid = 1'b0;
    #1; chk("t6_flushed", rsp_valid, 1'b0); chk("t6_busy", busy, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset       = ($urandom_range(0, 199) == 0);
      rsp_ready   = ($urandom_range(0, 9) < 6);
      fpu_pending = 4'($urandom) & 4'($urandom);
      drive($urandom_range(0, 9) < 7, 2'($urandom_range(1, 3)),
            addr_tab[$urandom_range(0, 5)], 2'($urandom),
            1'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), $urandom,
            {12'($urandom), 32'($urandom)});
    end
    @(negedge clk); reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
